// File: rtl/i2s_audio_out.sv
// rtl/i2s_audio_out.sv - I2S (Philips) stereo serializer with one-entry pending sample buffer
module i2s_audio_out #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    sCLK_XVXENVS,
  input  logic                    reset_reg,
  input  logic [SAMPLE_WIDTH-1:0] lsound_in,
  input  logic [SAMPLE_WIDTH-1:0] rsound_in,
  input  logic                    sample_valid,
  input  logic                    mute,
  input  logic                    flags_clr,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_data,
  output logic                    frame_start,
  output logic                    underrun,
  output logic                    overrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int PW = $clog2(FRAME_BITS);
  localparam int IW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(BCLK_DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] P_SLOT = PW'(SLOT_BITS);

  logic [DW-1:0]           d;
  logic [PW-1:0]           p;
  logic [SAMPLE_WIDTH-1:0] l_frame, r_frame;
  logic [SAMPLE_WIDTH-1:0] l_pend, r_pend;
  logic                    pend_full;

  logic                    bit_tick, load;
  logic [PW-1:0]           p_next, q;
  logic                    right;
  logic [IW-1:0]           idx;
  logic                    data_next;
  logic                    set_underrun, set_overrun;

  always_comb begin
    bit_tick  = (d == D_LAST) && i2s_bclk;
    load      = bit_tick && (p == P_LAST);
    p_next    = (p == P_LAST) ? '0 : p + 1'b1;
    right     = (p_next >= P_SLOT);
    q         = right ? (p_next - P_SLOT) : p_next;
    idx       = IW'(SAMPLE_WIDTH - int'(q));
    data_next = 1'b0;
    // Position q of a slot carries bit [SAMPLE_WIDTH-q]; q == 0 is the one-BCLK I2S delay slot.
    if ((q != '0) && (int'(q) <= SAMPLE_WIDTH)) begin
      data_next = right ? r_frame[idx] : l_frame[idx];
    end else if ((q == '0) && (SAMPLE_WIDTH == SLOT_BITS)) begin
      data_next = right ? l_frame[0] : r_frame[0];
    end
    set_underrun = load && !pend_full && !sample_valid && !mute;
    set_overrun  = sample_valid && pend_full && !load;
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset_reg) begin
      d           <= '0;
      p           <= P_LAST;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b1;
      i2s_data    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      l_frame     <= '0;
      r_frame     <= '0;
      l_pend      <= '0;
      r_pend      <= '0;
      pend_full   <= 1'b0;
    end else begin
      if (d == D_LAST) begin
        d        <= '0;
        i2s_bclk <= !i2s_bclk;
      end else begin
        d <= d + 1'b1;
      end

      if (bit_tick) begin
        p         <= p_next;
        i2s_lrclk <= right;
        i2s_data  <= data_next;
      end

      frame_start <= load;
      underrun    <= set_underrun || (underrun && !flags_clr);
      overrun     <= set_overrun  || (overrun  && !flags_clr);

      if (load) begin
        if (mute) begin
          l_frame <= '0;
          r_frame <= '0;
        end else if (pend_full) begin
          l_frame <= l_pend;
          r_frame <= r_pend;
        end else if (sample_valid) begin
          l_frame <= lsound_in;
          r_frame <= rsound_in;
        end else begin
          l_frame <= '0;
          r_frame <= '0;
        end
        // A strobe that meets a full buffer at load refills it; otherwise the buffer drains.
        if (pend_full && sample_valid) begin
          l_pend <= lsound_in;
          r_pend <= rsound_in;
        end else begin
          pend_full <= 1'b0;
        end
      end else if (sample_valid) begin
        l_pend    <= lsound_in;
        r_pend    <= rsound_in;
        pend_full <= 1'b1;
      end
    end
  end

endmodule
